// File: rtl/scoreboard_pkg.sv
// Shared constants, segment table and FSM state type for the score display driver.
package scoreboard_pkg;

    localparam int unsigned SCORE_W = 24;
    localparam int unsigned DIGITS  = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned SEG_W   = 7;

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Non-decimal nibbles cannot come out of the converter; show them blank anyway.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = SEG_BLANK;
        if (nib <= 4'd9) begin
            seg = SEG_DIGIT[nib];
        end
        return seg;
    endfunction

endpackage

// File: rtl/score_display_driver_if.sv
// Score load strobe, refresh digit index and display pin bundle.
interface score_display_driver_if;
    import scoreboard_pkg::*;

    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic [SEL_W-1:0]   digit_sel;
    logic [DIGITS-1:0]  anode;
    logic [SEG_W-1:0]   cathode;
    logic               dp;
    logic               busy;

    modport master (
        output score, score_valid, digit_sel,
        input  anode, cathode, dp, busy
    );

    modport slave (
        input  score, score_valid, digit_sel,
        output anode, cathode, dp, busy
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep pending score and a stable BCD snapshot.
module bin2bcd_seq
    import scoreboard_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic               score_valid_i,
    output logic [BCD_W-1:0]   bcd_o,
    output logic               busy_o
);

    state_e             state_q;
    logic [SCORE_W-1:0] bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   snap_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pend_q;
    logic [SCORE_W-1:0] pend_score_q;
    logic               busy_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [3:0]         nib;

    // Add 3 to every working nibble that is 5 or more before the next shift
    always_comb begin
        bcd_adj = bcd_q;
        nib     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = bcd_q[4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
        end
    end

    // Conversion FSM, pending capture and snapshot update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            snap_q       <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_score_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (score_valid_i) begin
                        bin_q   <= score_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                    bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
                    cnt_q <= CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                        state_q <= DONE;
                    end
                    if (score_valid_i) begin
                        pend_q       <= 1'b1;
                        pend_score_q <= score_i;
                    end
                end
                DONE: begin
                    snap_q <= bcd_q;
                    // A strobe landing in this cycle is newer than any stored pending score
                    if (score_valid_i || pend_q) begin
                        bin_q   <= score_valid_i ? score_i : pend_score_q;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd_o  = snap_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/score_display_driver.sv
// Binary score to 8-digit multiplexed seven-segment display with leading-zero blanking.
module score_display_driver
    import scoreboard_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    score_display_driver_if.slave  bus
);

    logic [BCD_W-1:0]  bcd_snap;
    logic              conv_busy;

    logic [DIGITS-1:0] blank;
    logic              upper_zero;
    logic [3:0]        sel_nib;
    logic [DIGITS-1:0] anode_d;
    logic [SEG_W-1:0]  cathode_d;

    logic [DIGITS-1:0] anode_q;
    logic [SEG_W-1:0]  cathode_q;
    logic              dp_q;

    bin2bcd_seq u_conv (
        .clk_i         (clock),
        .rst_i         (reset),
        .score_i       (bus.score),
        .score_valid_i (bus.score_valid),
        .bcd_o         (bcd_snap),
        .busy_o        (conv_busy)
    );

    // Blank a digit when it and every more-significant digit are zero; digit 0 always shows
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (bcd_snap[4*i +: 4] == 4'd0);
            blank[i]   = (i != 0) && upper_zero;
        end
    end

    // Select the digit addressed by the refresh counter
    always_comb begin
        sel_nib = bcd_snap[{bus.digit_sel, 2'b00} +: 4];
        if (blank[bus.digit_sel]) begin
            anode_d   = '1;
            cathode_d = SEG_BLANK;
        end else begin
            anode_d   = ~(DIGITS'(1) << bus.digit_sel);
            cathode_d = seg_encode(sel_nib);
        end
    end

    // Registered display pins
    always_ff @(posedge clock) begin
        if (reset) begin
            anode_q   <= '1;
            cathode_q <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            dp_q      <= 1'b1;
        end
    end

    assign bus.anode   = anode_q;
    assign bus.cathode = cathode_q;
    assign bus.dp      = dp_q;
    assign bus.busy    = conv_busy;

endmodule

// File: tb/tb_score_display_driver.sv
// Directed checks of conversion latency, digit mux, blanking, pending reload and reset abort.
module tb_score_display_driver;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    score_display_driver_if bus ();

    score_display_driver dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe a score; returns at the falling edge after the sampling edge
    task automatic strobe(input logic [23:0] v);
        @(negedge clock);
        bus.score       = v;
        bus.score_valid = 1'b1;
        @(negedge clock);
        bus.score_valid = 1'b0;
    endtask

    // Count falling edges with busy high, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic read_digit(input int i, input logic [7:0] ea, input logic [6:0] ec, input string tag);
        @(negedge clock);
        bus.digit_sel = 3'(i);
        @(negedge clock);
        check({tag, "_anode"}, 32'(bus.anode), 32'(ea));
        check({tag, "_cath"}, 32'(bus.cathode), 32'(ec));
    endtask

    // Check all 8 digits against a decimal digit list (LS first), blanking above the top digit
    task automatic sweep(input int v, input string tag);
        int d[8];
        int top;
        int t;
        t   = v;
        top = 0;
        for (int i = 0; i < 8; i++) begin
            d[i] = t % 10;
            t    = t / 10;
            if (d[i] != 0) top = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (i > top)
                read_digit(i, 8'hFF, 7'h7F, $sformatf("%s_d%0d", tag, i));
            else
                read_digit(i, ~(8'(1) << i), seg_of(d[i]), $sformatf("%s_d%0d", tag, i));
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        bus.score       = '0;
        bus.score_valid = 1'b0;
        bus.digit_sel   = 3'd0;
        reset           = 1'b1;

        repeat (3) @(negedge clock);
        check("rst_anode", 32'(bus.anode), 32'hFF);
        check("rst_cath", 32'(bus.cathode), 32'h7F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("rel_anode", 32'(bus.anode), 32'hFE);
        check("rel_cath", 32'(bus.cathode), 32'h40);
        check("rel_busy", 32'(bus.busy), 32'h0);

        // 1234: busy exactly 25 cycles
        strobe(24'd1234);
        wait_idle(n);
        check("b1234_busy_len", 32'(n), 32'd25);
        sweep(1234, "s1234");
        check("dp_off", 32'(bus.dp), 32'h1);

        strobe(24'd16777215);
        wait_idle(n);
        check("bmax_busy_len", 32'(n), 32'd25);
        sweep(16777215, "smax");

        strobe(24'd100);
        wait_idle(n);
        sweep(100, "s100");

        // Zero from a nonzero snapshot: only digit 0 lit
        strobe(24'd0);
        wait_idle(n);
        sweep(0, "s0");

        // 500 then 42 five cycles later; display follows digit 2
        @(negedge clock);
        bus.digit_sel = 3'd2;
        strobe(24'd500);
        repeat (4) @(negedge clock);
        bus.score       = 24'd42;
        bus.score_valid = 1'b1;
        @(negedge clock);
        bus.score_valid = 1'b0;
        // now after edge 5; step to after edge 25
        repeat (20) @(negedge clock);
        check("p_busy_e25", 32'(bus.busy), 32'h1);
        check("p_old_disp", 32'(bus.cathode), 32'h7F);
        @(negedge clock);
        check("p_busy_e26", 32'(bus.busy), 32'h1);
        check("p_500_anode", 32'(bus.anode), 32'hFB);
        check("p_500_cath", 32'(bus.cathode), 32'(seg_of(5)));
        wait_idle(n);
        check("p_done", 32'(n < 200), 32'h1);
        sweep(42, "s42");

        // Reset mid-conversion with a pending score
        @(negedge clock);
        bus.digit_sel = 3'd0;
        strobe(24'd999);
        repeat (4) @(negedge clock);
        bus.score       = 24'd7;
        bus.score_valid = 1'b1;
        @(negedge clock);
        bus.score_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("ab_busy", 32'(bus.busy), 32'h0);
        @(negedge clock);
        check("ab_anode", 32'(bus.anode), 32'hFE);
        check("ab_cath", 32'(bus.cathode), 32'h40);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (bus.busy !== 1'b0) n++;
        end
        check("ab_no_restart", 32'(n), 32'd0);
        sweep(0, "sab");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
